// File: rtl/cmp_crossing_monitor_if.sv
// cmp_crossing_monitor_if: comparator-flag sample bus and monitor status outputs
//   master: drives in_valid, less, equal, greater, clear; reads the status outputs
//   slave : the monitor side, reads the flags and drives state/pulse/match/error/counters
interface cmp_crossing_monitor_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic             less;
  logic             equal;
  logic             greater;
  logic             clear;
  logic [1:0]       state_o;
  logic             rise_o;
  logic             fall_o;
  logic             match_o;
  logic             onehot_err_o;
  logic [CNT_W-1:0] rise_cnt_o;
  logic [CNT_W-1:0] fall_cnt_o;
  modport master (
    output in_valid, less, equal, greater, clear,
    input  state_o, rise_o, fall_o, match_o, onehot_err_o, rise_cnt_o, fall_cnt_o
  );
  modport slave (
    input  in_valid, less, equal, greater, clear,
    output state_o, rise_o, fall_o, match_o, onehot_err_o, rise_cnt_o, fall_cnt_o
  );
endinterface

// File: rtl/cmp_crossing_monitor.sv
// cmp_crossing_monitor: debounces comparator flags into BELOW/ABOVE state with crossing pulses, counters, match and error
//   clk, rst : clock, asynchronous active-high reset
//   bus      : in_valid/less/equal/greater/clear in; state_o (00 IDLE, 01 BELOW, 10 ABOVE),
//              rise_o/fall_o pulses, match_o level, sticky onehot_err_o, saturating rise/fall counters out
module cmp_crossing_monitor #(
  parameter int DEBOUNCE  = 2,
  parameter int MATCH_LEN = 4,
  parameter int CNT_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  cmp_crossing_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, BELOW = 2'b01, ABOVE = 2'b10} st_t;
  typedef enum logic [1:0] {P_NONE, P_LT, P_GT} dir_t;
  st_t              st;
  dir_t             pend_dir;
  logic [3:0]       pend_cnt;
  logic [7:0]       eq_run;
  logic             rise, fall, match, err;
  logic [CNT_W-1:0] rise_cnt, fall_cnt;
  logic             legal, at_target, flip;
  st_t              target;
  dir_t             want;
  logic [3:0]       pend_nxt;
  logic [7:0]       eq_nxt;
  always_comb begin
    legal     = $onehot({bus.less, bus.equal, bus.greater});
    target    = bus.greater ? ABOVE : BELOW;
    want      = bus.greater ? P_GT : P_LT;
    at_target = st == target;
    // a direction change restarts the debounce count at this sample
    pend_nxt  = pend_dir == want ? pend_cnt + 4'd1 : 4'd1;
    flip      = !at_target && pend_nxt == 4'(DEBOUNCE);
    eq_nxt    = eq_run == 8'(MATCH_LEN) ? eq_run : eq_run + 8'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      pend_dir <= P_NONE;
      pend_cnt <= '0;
      eq_run   <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      match    <= 1'b0;
      err      <= 1'b0;
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else if (bus.clear) begin
      st       <= IDLE;
      pend_dir <= P_NONE;
      pend_cnt <= '0;
      eq_run   <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      match    <= 1'b0;
      err      <= 1'b0;
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (bus.in_valid) begin
        if (!legal) begin
          err      <= 1'b1;
          pend_cnt <= '0;
          eq_run   <= '0;
          match    <= 1'b0;
        end else if (bus.equal) begin
          pend_dir <= P_NONE;
          pend_cnt <= '0;
          eq_run   <= eq_nxt;
          match    <= eq_nxt == 8'(MATCH_LEN);
        end else begin
          eq_run <= '0;
          match  <= 1'b0;
          if (at_target) pend_cnt <= '0;
          else begin
            pend_dir <= want;
            pend_cnt <= flip ? 4'd0 : pend_nxt;
            if (flip) begin
              st <= target;
              // leaving IDLE settles the state silently; only true crossings pulse and count
              if (bus.greater && st == BELOW) begin
                rise     <= 1'b1;
                rise_cnt <= rise_cnt == '1 ? rise_cnt : rise_cnt + 1'b1;
              end
              if (bus.less && st == ABOVE) begin
                fall     <= 1'b1;
                fall_cnt <= fall_cnt == '1 ? fall_cnt : fall_cnt + 1'b1;
              end
            end
          end
        end
      end
    end
  end
  assign bus.state_o      = st;
  assign bus.rise_o       = rise;
  assign bus.fall_o       = fall;
  assign bus.match_o      = match;
  assign bus.onehot_err_o = err;
  assign bus.rise_cnt_o   = rise_cnt;
  assign bus.fall_cnt_o   = fall_cnt;
endmodule

// File: tb/tb_cmp_crossing_monitor.sv
// tb_cmp_crossing_monitor: directed checks of the crossing monitor, default and 2-bit-counter instances in lockstep
module tb_cmp_crossing_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  cmp_crossing_monitor_if #(.CNT_W(8)) bus ();
  cmp_crossing_monitor_if #(.CNT_W(2)) bus2 ();
  assign bus2.in_valid = bus.in_valid;
  assign bus2.less     = bus.less;
  assign bus2.equal    = bus.equal;
  assign bus2.greater  = bus.greater;
  assign bus2.clear    = bus.clear;
  cmp_crossing_monitor #(.DEBOUNCE(2), .MATCH_LEN(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  cmp_crossing_monitor #(.DEBOUNCE(2), .MATCH_LEN(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic smp(input logic l, input logic e, input logic g);
    bus.in_valid = 1'b1;
    bus.less     = l;
    bus.equal    = e;
    bus.greater  = g;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.less     = 1'b0;
    bus.equal    = 1'b0;
    bus.greater  = 1'b0;
    bus.clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset state", int'(bus.state_o), 0);
    check("reset err", int'(bus.onehot_err_o), 0);
    check("reset match", int'(bus.match_o), 0);
    check("reset rise_cnt", int'(bus.rise_cnt_o), 0);
    // 1: IDLE -> ABOVE with no pulse
    smp(0, 0, 1);
    check("t1 debounce hold", int'(bus.state_o), 0);
    smp(0, 0, 1);
    check("t1 above", int'(bus.state_o), 2);
    check("t1 no rise from idle", int'(bus.rise_o), 0);
    check("t1 rise_cnt", int'(bus.rise_cnt_o), 0);
    // 2: ABOVE -> BELOW with single-cycle fall
    smp(1, 0, 0);
    check("t2 pending", int'(bus.state_o), 2);
    smp(1, 0, 0);
    check("t2 below", int'(bus.state_o), 1);
    check("t2 fall pulse", int'(bus.fall_o), 1);
    check("t2 fall_cnt", int'(bus.fall_cnt_o), 1);
    idle();
    check("t2 fall one cycle", int'(bus.fall_o), 0);
    // 3: equal interrupts the debounce
    smp(0, 0, 1);
    smp(0, 0, 1);
    check("t3 rise pulse", int'(bus.rise_o), 1);
    check("t3 rise_cnt", int'(bus.rise_cnt_o), 1);
    smp(1, 0, 0);
    smp(0, 1, 0);
    smp(1, 0, 0);
    check("t3 equal resets pend", int'(bus.state_o), 2);
    smp(1, 0, 0);
    check("t3 below", int'(bus.state_o), 1);
    check("t3 fall_cnt", int'(bus.fall_cnt_o), 2);
    // 4: sustained equality with gaps
    for (int i = 1; i <= 5; i++) begin
      smp(0, 1, 0);
      check($sformatf("t4 match eq%0d", i), int'(bus.match_o), i >= 4 ? 1 : 0);
      idle();
      check($sformatf("t4 match gap%0d", i), int'(bus.match_o), i >= 4 ? 1 : 0);
    end
    smp(0, 0, 1);
    check("t4 match drop", int'(bus.match_o), 0);
    check("t4 state held", int'(bus.state_o), 1);
    // 5: illegal flags, sticky error, pend reset, then clear
    smp(1, 0, 1);
    check("t5 err set", int'(bus.onehot_err_o), 1);
    smp(0, 0, 0);
    check("t5 err sticky", int'(bus.onehot_err_o), 1);
    check("t5 state kept", int'(bus.state_o), 1);
    check("t5 rise_cnt kept", int'(bus.rise_cnt_o), 1);
    check("t5 fall_cnt kept", int'(bus.fall_cnt_o), 2);
    smp(0, 0, 1);
    check("t5 pend cleared by illegal", int'(bus.state_o), 1);
    bus.clear = 1'b1;
    smp(0, 0, 1);
    bus.clear = 1'b0;
    check("t5 clear err", int'(bus.onehot_err_o), 0);
    check("t5 clear state", int'(bus.state_o), 0);
    check("t5 clear rise_cnt", int'(bus.rise_cnt_o), 0);
    check("t5 clear fall_cnt", int'(bus.fall_cnt_o), 0);
    smp(0, 0, 1);
    check("t5 clear ignored sample", int'(bus.state_o), 0);
    // 6: counter saturation in the 2-bit instance
    smp(0, 0, 1);
    check("t6 above", int'(bus.state_o), 2);
    for (int k = 1; k <= 4; k++) begin
      smp(1, 0, 0);
      smp(1, 0, 0);
      check($sformatf("t6 fall%0d", k), int'(bus.fall_o), 1);
      smp(0, 0, 1);
      smp(0, 0, 1);
      check($sformatf("t6 rise%0d", k), int'(bus2.rise_o), 1);
      check($sformatf("t6 cnt8 %0d", k), int'(bus.rise_cnt_o), k);
      check($sformatf("t6 cnt2 %0d", k), int'(bus2.rise_cnt_o), k > 3 ? 3 : k);
    end
    check("t6 fall_cnt2 sat", int'(bus2.fall_cnt_o), 3);
    check("t6 fall_cnt8", int'(bus.fall_cnt_o), 4);
    smp(1, 0, 0);
    rst = 1'b1;
    #1;
    check("t6 async state", int'(bus.state_o), 0);
    check("t6 async cnt8", int'(bus.rise_cnt_o), 0);
    check("t6 async cnt2", int'(bus2.rise_cnt_o), 0);
    check("t6 async fall2", int'(bus2.fall_cnt_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    smp(0, 0, 1);
    smp(0, 0, 1);
    check("t6 post reset above", int'(bus.state_o), 2);
    check("t6 post reset no rise", int'(bus.rise_o), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
